// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a sync_fifo and its producer/consumer.
// The master drives requests and write data; the slave (the FIFO) drives status and read data.
interface sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             enable;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             err_clr;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output enable, wr_en, wr_data, rd_en, err_clr,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  enable, wr_en, wr_data, rd_en, err_clr,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO of arbitrary depth with occupancy count and threshold flags.
// Define SYNC_FIFO_ERR_FLAG_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input logic       clk,
  input logic       rst_n,
  sync_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_rdAcc;
  logic             w_wrAcc;
  logic [PTR_W-1:0] w_wrPtrNext;
  logic [PTR_W-1:0] w_rdPtrNext;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // A full FIFO still takes a write when the head pops in the same cycle.
  assign w_rdAcc = bus.enable & bus.rd_en & ~w_empty;
  assign w_wrAcc = bus.enable & bus.wr_en & (~w_full | w_rdAcc);

  assign w_wrPtrNext = (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
  assign w_rdPtrNext = (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (w_wrAcc) begin
      r_mem[r_wrPtr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wrAcc) begin
        r_wrPtr <= w_wrPtrNext;
      end
      if (w_rdAcc) begin
        r_rdPtr <= w_rdPtrNext;
      end
      if (w_wrAcc && !w_rdAcc) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_rdAcc && !w_wrAcc) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign bus.count        = r_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = (r_count >= CNT_W'(AFULL_LVL));
  assign bus.almost_empty = (r_count <= CNT_W'(AEMPTY_LVL));
  assign bus.rd_data      = w_empty ? '0 : r_mem[r_rdPtr];

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovSet;
  logic w_unSet;

  assign w_ovSet = bus.enable & bus.wr_en & ~w_wrAcc;
  assign w_unSet = bus.enable & bus.rd_en & w_empty;

  // A new error in the same cycle as err_clr must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovSet) begin
        r_overflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_unSet) begin
        r_underflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`else
  logic w_unusedErrClr;
  assign w_unusedErrClr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised scoreboard bench for sync_fifo (DEPTH=5, AFULL_LVL=4, AEMPTY_LVL=1) using a queue reference model.
// A driver predicts each cycle's state and popped words; a separate monitor compares what the DUT presents.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AFULL = 4;
  localparam int AEMPTY = 1;

  typedef struct {
    int         cnt;
    logic       emp;
    logic       ful;
    logic       af;
    logic       ae;
    logic [7:0] head;
    logic       ovf;
    logic       unf;
  } snap_t;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  logic [7:0] modelQ[$];
  logic [7:0] expQ[$];
  snap_t      stateQ[$];
  logic       modelOvf;
  logic       modelUnf;

  sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AFULL_LVL(AFULL),
    .AEMPTY_LVL(AEMPTY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Records the state the DUT should show this cycle, drives inputs, then advances the model past the edge.
  task automatic applyStimulus(input logic en, input logic wr, input logic [7:0] wd,
                               input logic rd, input logic clr);
    snap_t s;
    bit    rdOk;
    bit    wrOk;
    bit    wasEmpty;
    bit    ovSet;
    bit    unSet;
    s.cnt  = modelQ.size();
    s.emp  = (modelQ.size() == 0);
    s.ful  = (modelQ.size() == DEPTH);
    s.af   = (modelQ.size() >= AFULL);
    s.ae   = (modelQ.size() <= AEMPTY);
    s.head = (modelQ.size() > 0) ? modelQ[0] : 8'h00;
    s.ovf  = modelOvf;
    s.unf  = modelUnf;
    stateQ.push_back(s);

    bus.enable  = en;
    bus.wr_en   = wr;
    bus.wr_data = wd;
    bus.rd_en   = rd;
    bus.err_clr = clr;

    wasEmpty = (modelQ.size() == 0);
    rdOk = en && rd && !wasEmpty;
    wrOk = en && wr && ((modelQ.size() < DEPTH) || rdOk);
    if (rdOk) expQ.push_back(modelQ.pop_front());
    if (wrOk) modelQ.push_back(wd);

`ifdef SYNC_FIFO_ERR_FLAG_EN
    ovSet = en && wr && !wrOk;
    unSet = en && rd && wasEmpty;
    if (ovSet) modelOvf = 1'b1;
    else if (clr) modelOvf = 1'b0;
    if (unSet) modelUnf = 1'b1;
    else if (clr) modelUnf = 1'b0;
`else
    ovSet = 1'b0;
    unSet = 1'b0;
    if (ovSet || unSet) modelOvf = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: compares snapshot state and any popped word well before the next rising edge.
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      #3;
      if (stateQ.size() > 0) begin
        s = stateQ.pop_front();
        checkOutput("count", 32'(bus.count), 32'(s.cnt));
        checkOutput("empty", 32'(bus.empty), 32'(s.emp));
        checkOutput("full", 32'(bus.full), 32'(s.ful));
        checkOutput("almostFull", 32'(bus.almost_full), 32'(s.af));
        checkOutput("almostEmpty", 32'(bus.almost_empty), 32'(s.ae));
        checkOutput("head", 32'(bus.rd_data), 32'(s.head));
        checkOutput("overflow", 32'(bus.overflow), 32'(s.ovf));
        checkOutput("underflow", 32'(bus.underflow), 32'(s.unf));
        if (bus.enable && bus.rd_en && !bus.empty) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedRead actual=%0h expected=none at %0t", bus.rd_data, $time);
          end else begin
            checkOutput("readData", 32'(bus.rd_data), 32'(expQ.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    modelOvf    = 1'b0;
    modelUnf    = 1'b0;
    rst_n       = 1'b0;
    bus.enable  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;

    #5;
    checkOutput("rstCount", 32'(bus.count), 32'd0);
    checkOutput("rstEmpty", 32'(bus.empty), 32'd1);
    checkOutput("rstFull", 32'(bus.full), 32'd0);
    checkOutput("rstAlmostEmpty", 32'(bus.almost_empty), 32'd1);
    checkOutput("rstAlmostFull", 32'(bus.almost_full), 32'd0);
    checkOutput("rstRdData", 32'(bus.rd_data), 32'd0);
    checkOutput("rstOverflow", 32'(bus.overflow), 32'd0);
    checkOutput("rstUnderflow", 32'(bus.underflow), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    idle();

    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'h88, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0);
    idle();

    #4 rst_n = 1'b0;
    #1;
    checkOutput("midRstCount", 32'(bus.count), 32'd0);
    checkOutput("midRstEmpty", 32'(bus.empty), 32'd1);
    checkOutput("midRstRdData", 32'(bus.rd_data), 32'd0);
    modelQ.delete();
    expQ.delete();
    modelOvf = 1'b0;
    modelUnf = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    idle();
    #5;
    checkOutput("pendingReads", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO that replaces the edge-triggered queue used on the UART/RF data paths. Writes and reads are sampled on `clk` with enable strobes instead of clocking on the strobe edges. The block adds:
- support for any depth, not only powers of two;
- an occupancy count and programmable almost-full/almost-empty thresholds;
- a clock-enable sleep input;
- guaranteed pass-through when read and write hit the same cycle.

It sits between the UART RX/TX engines and the RF packet controller.

## Interface
Parameters:
- `WIDTH`, 8: data word width in bits (≥1).
- `DEPTH`, 32: number of storage entries. Any integer ≥2; power of two not required.
- `AFULL_LVL`, `DEPTH-1`: `almost_full` asserts when `count >= AFULL_LVL` (1..`DEPTH`).
- `AEMPTY_LVL`, 1: `almost_empty` asserts when `count <= AEMPTY_LVL` (0..`DEPTH-1`).
- `CNT_W`, `$clog2(DEPTH+1)`: derived; not overridden.

Ports:
- `clk`, in, 1: rising-edge clock for all state.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: when low, the FIFO sleeps and `wr_en`/`rd_en` are ignored.
- `wr_en`, in, 1: write request.
- `wr_data`, in, `WIDTH`: write word.
- `rd_en`, in, 1: read (pop) request.
- `rd_data`, out, `WIDTH`: head word, first-word-fall-through.
- `full`, `empty`, out, 1: `count == DEPTH` / `count == 0`.
- `almost_full`, `almost_empty`, out, 1: threshold flags.
- `count`, out, `CNT_W`: current occupancy, 0..`DEPTH`.
- `overflow`, `underflow`, out, 1: sticky error flags (see Configuration).
- `err_clr`, in, 1: clears the sticky error flags.

## Operation
- **Storage:** `mem[0..DEPTH-1]`, plus `wr_ptr` and `rd_ptr` of width `$clog2(DEPTH)`. Each pointer wraps from `DEPTH-1` to 0 by explicit compare, never by natural overflow.
- **Accepts:**
  - `rd_acc = enable & rd_en & !empty`.
  - `wr_acc = enable & wr_en & (!full | rd_acc)`.
  - So a write into a full FIFO succeeds only if a pop happens in the same cycle.
- **Empty + simultaneous rd_en/wr_en:** the read is rejected and the write is accepted. The head is never bypassed from `wr_data`.
- **Write:** on `wr_acc`, `mem[wr_ptr] <= wr_data` and `wr_ptr` advances.
- **Read:** on `rd_acc`, `rd_ptr` advances.
- **Count update:** `count` +1 on write only, −1 on read only, unchanged when both or neither are accepted. `count` never leaves 0..`DEPTH`.
- **Flags:** `full`, `empty`, `almost_full` and `almost_empty` decode combinationally from the `count` register only. They are never decoded from `wr_en`/`rd_en`.
- **rd_data:** equals `mem[rd_ptr]` when `!empty`, and is forced to 0 when empty.
- **Sleep:** while `enable` is low, pointers, `count`, memory and flags hold their values.
- **Reset:** asynchronous reset mid-transfer clears the pointers, `count` and the error flags immediately. Memory contents are not cleared and become unreachable.

## Timing
- **Reset values:**
  - `count` = 0, `empty` = 1, `full` = 0.
  - `almost_empty` = 1; `almost_full` = 0.
  - `rd_data` = 0, `overflow` = 0, `underflow` = 0.
- **Write latency:** a word written at edge N appears on `rd_data`, and `empty` drops, immediately after edge N (first-word-fall-through, one cycle write-to-read).
- **Read:** `rd_data` is valid during the cycle in which `rd_en` is sampled. The next word, or 0, appears after that edge.
- **Flag timing:** flags and `count` change only on `clk` edges or on reset assertion.
- **Throughput:** one write and one read per cycle sustained, at any occupancy 1..`DEPTH`.

## Configuration
- **Macro:** `SYNC_FIFO_ERR_FLAG_EN`.
- **Defined:**
  - `overflow` sets on `enable & wr_en & !wr_acc`.
  - `underflow` sets on `enable & rd_en & empty`.
  - Both flags are sticky until `err_clr` is sampled high or reset.
  - If a set and `err_clr` occur in the same cycle, set wins.
- **Undefined:**
  - `overflow` and `underflow` are tied to 0.
  - `err_clr` is ignored.
  - No error flip-flops are synthesised.

## Test plan
- **Reset then fill:** `DEPTH`=5, `AFULL_LVL`=4, `AEMPTY_LVL`=1. Reset, then write `0x11..0x55` on 5 consecutive cycles.
  - `count` 1,2,3,4,5.
  - `almost_empty` falls at count 2; `almost_full` rises at 4; `full` rises at 5.
  - `rd_data` = `0x11` throughout.
- **Drain with wrap:** continue with 5 reads, then write `0x66` and read it.
  - Reads return `0x11..0x55` in order.
  - `0x66` is stored at index 0 (pointer wrapped from 4 to 0) and returned.
  - `empty` = 1 and `rd_data` = 0 at the end.
- **Full + simultaneous:** with the FIFO full, assert `wr_en`+`rd_en` with `0x77`.
  - `count` stays 5, the head pops, and `0x77` is stored with no overflow.
- **Empty + simultaneous:** with the FIFO empty, assert `rd_en`+`wr_en` with `0x88`.
  - `count` becomes 1 and `rd_data` = `0x88`.
  - `underflow` = 1 with the macro defined, 0 without.
- **Sleep and error clear:** hold `enable`=0 with `wr_en`=1 for 3 cycles; then, with the FIFO full, write with `enable`=1; then pulse `err_clr`.
  - During sleep, `count` is unchanged.
  - The full-FIFO write sets `overflow` = 1 with the macro defined.
  - `err_clr` returns `overflow` to 0 on the next edge.
- **Reset mid-operation:** at `count` = 3, pulse `rst_n` low between clock edges.
  - `count` = 0, `empty` = 1 and `rd_data` = 0 asynchronously.
  - The next write `0x99` reads back as `0x99`.
